// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-port bundle shared by producers and arbiter
interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;
  modport master (
    output req_valid, req_data, full, almostfull, wr_ack, overflow,
    input  req_ready, wr_en, data_in
  );
  modport slave (
    input  req_valid, req_data, full, almostfull, wr_ack, overflow,
    output req_ready, wr_en, data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_wr_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                ack_cnt,
  output logic [15:0]                drop_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d, last_q, last_d, pick, idx;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [15:0]           ack_q, ack_d, drop_q, drop_d;
  logic                  throttle, accept;
  assign throttle      = bus.full || (bus.almostfull && wr_en_q);
  assign accept        = state_q == GRANT && !throttle && bus.req_valid[owner_q];
  assign bus.req_ready = (state_q == GRANT && !throttle) ? NUM_REQ'(1) << owner_q : '0;
  assign bus.wr_en     = wr_en_q;
  assign bus.data_in   = data_q;
  assign grant_id      = owner_q;
  assign busy          = state_q == GRANT;
  assign ack_cnt       = ack_q;
  assign drop_cnt      = drop_q;
  always_comb begin
    pick = last_q;
    idx  = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = accept ? cnt_q + 4'd1 : cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (|bus.req_valid) begin
        state_d = GRANT;
        owner_d = pick;
      end
    end else if (!bus.req_valid[owner_q] || (accept && cnt_q + 4'd1 == 4'(MAX_BURST))) begin
      state_d = IDLE;
      last_d  = owner_q;
      cnt_d   = '0;
    end
    wr_en_d = accept;
    data_d  = accept ? bus.req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH] : data_q;
    ack_d   = (bus.wr_ack && ack_q != 16'hFFFF) ? ack_q + 16'd1 : ack_q;
    drop_d  = (bus.overflow && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus multi-cycle sequences for the FIFO write arbiter
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] ack_cnt, drop_cnt;
  int          checks = 0;
  int          errors = 0;
  int          p, b;
  logic [1:0]  eg;
  logic        eb, ew;
  logic [15:0] rd [4];
  typedef struct {
    logic [3:0]  rv;
    logic        full;
    logic        af;
    logic        busy;
    logic [1:0]  gid;
    logic [3:0]  rdy;
    logic        wr;
    logic [15:0] din;
  } vec_t;
  vec_t tbl [24];
  fifo_wr_arbiter_if #(.FIFO_WIDTH(16), .NUM_REQ(4)) bus ();
  fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy),
    .ack_cnt  (ack_cnt),
    .drop_cnt (drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rd = '{16'hA5A5, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    tbl = '{
      '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'h0000},
      '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'h0000},
      '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 16'h0000},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 16'hA5A5},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hA5A5},
      '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hA5A5},
      '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 16'hA5A5},
      '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'hA5A5},
      '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'hB1B1},
      '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 16'hB1B1},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'hB1B1},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hB1B1},
      '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hB1B1},
      '{4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 16'hB1B1},
      '{4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 16'hC2C2},
      '{4'b1011, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 16'hC2C2},
      '{4'b1011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hC2C2},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 16'hC2C2},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'hC2C2}
    };
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = {rd[3], rd[2], rd[1], rd[0]};
    bus.full       = 1'b0;
    bus.almostfull = 1'b0;
    bus.wr_ack     = 1'b0;
    bus.overflow   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset grant_id", 32'(grant_id), 32'd0);
    chk("reset ack_cnt", 32'(ack_cnt), 32'd0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 24; i++) begin
      bus.req_valid  = tbl[i].rv;
      bus.full       = tbl[i].full;
      bus.almostfull = tbl[i].af;
      #2;
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].busy) chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d wr_en", i), 32'(bus.wr_en), 32'(tbl[i].wr));
      chk($sformatf("row%0d data_in", i), 32'(bus.data_in), 32'(tbl[i].din));
      step();
    end
    bus.full       = 1'b0;
    bus.almostfull = 1'b0;
    bus.req_valid  = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      p  = c % 5;
      b  = c / 5;
      eb = p != 0;
      eg = 2'(b % 4);
      ew = p >= 2 || (p == 0 && c > 0);
      #2;
      chk($sformatf("rr%0d busy", c), 32'(busy), 32'(eb));
      if (eb) chk($sformatf("rr%0d grant_id", c), 32'(grant_id), 32'(eg));
      chk($sformatf("rr%0d req_ready", c), 32'(bus.req_ready), eb ? 32'(4'b0001 << eg) : 32'd0);
      chk($sformatf("rr%0d wr_en", c), 32'(bus.wr_en), 32'(ew));
      if (ew) chk($sformatf("rr%0d data_in", c), 32'(bus.data_in), 32'(rd[p == 0 ? (b + 3) % 4 : b % 4]));
      step();
    end
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      bus.wr_ack   = 1'b1;
      bus.overflow = c < 3;
      step();
    end
    bus.wr_ack   = 1'b0;
    bus.overflow = 1'b0;
    step();
    chk("ack_cnt after 5 pulses", 32'(ack_cnt), 32'd5);
    chk("drop_cnt after 3 pulses", 32'(drop_cnt), 32'd3);
    bus.req_valid = 4'b0001;
    step();
    step();
    chk("pre-reset wr_en", 32'(bus.wr_en), 32'd1);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset grant_id", 32'(grant_id), 32'd0);
    chk("async reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("async reset wr_en", 32'(bus.wr_en), 32'd0);
    chk("async reset data_in", 32'(bus.data_in), 32'd0);
    chk("async reset ack_cnt", 32'(ack_cnt), 32'd0);
    chk("async reset drop_cnt", 32'(drop_cnt), 32'd0);
    step();
    rst_n         = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("post-reset%0d wr_en", c), 32'(bus.wr_en), 32'd0);
      chk($sformatf("post-reset%0d busy", c), 32'(busy), 32'd0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16: data width of each requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4 (legal 2..8): number of producers sharing one FIFO write port.
REQ-003 Parameter MAX_BURST, default 4 (legal 1..15): maximum accepted beats per grant before rotation.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-007 req_data  input  NUM_REQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot-or-zero accept strobe; beat transfers when req_valid[i] && req_ready[i].
REQ-009 wr_en  output  1  registered FIFO write enable.
REQ-010 data_in  output  FIFO_WIDTH  registered FIFO write data.
REQ-011 full, almostfull, wr_ack, overflow  input  1 each  FIFO status, same meaning as the FIFO's own outputs.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of current owner; valid while busy=1.
REQ-013 busy  output  1  high in state GRANT.
REQ-014 ack_cnt, drop_cnt  output  16 each  saturating counts of wr_ack and overflow pulses.

Function
REQ-015 FSM states IDLE and GRANT only.
REQ-016 IDLE: if any req_valid, pick owner by round-robin starting at (last_owner+1) mod NUM_REQ, go to GRANT next cycle, beat count cleared; else stay.
REQ-017 No beat accepted in IDLE; req_ready all zero in IDLE.
REQ-018 throttle = full || (almostfull && wr_en); in GRANT req_ready[owner] = !throttle, all other bits 0 (combinational).
REQ-019 Accepted beat: next cycle wr_en=1 and data_in=that requester's req_data; otherwise next cycle wr_en=0 and data_in holds its value.
REQ-020 Beat counter increments per accepted beat; 4-bit wide.
REQ-021 GRANT -> IDLE when owner's req_valid is 0, or when an accepted beat makes count reach MAX_BURST; last_owner updated to owner on exit.
REQ-022 Throttle stalls in GRANT without leaving the state and without counting beats.
REQ-023 Back-to-back bursts from different requesters have exactly one IDLE cycle between them; a sole active requester regains the grant after that cycle.
REQ-024 ack_cnt increments on each cycle wr_ack=1; drop_cnt on each cycle overflow=1; both stop at 16'hFFFF.
REQ-025 Requester data is sampled only on an accepted beat; req_data of non-owners is ignored.

Reset
REQ-026 rst_n low forces immediately: state IDLE, last_owner=NUM_REQ-1 (requester 0 wins first), beat count 0, wr_en=0, data_in=0, busy=0, grant_id=0, ack_cnt=0, drop_cnt=0, req_ready=0.
REQ-027 Reset mid-burst discards the burst; no wr_en pulse after reset deasserts until a new grant and accepted beat.

Verification
REQ-028 Reset, req_valid=4'b0001, req_data[0]=16'hA5A5, FIFO not full -> busy next cycle, req_ready=4'b0001, wr_en=1 with data_in=16'hA5A5 one cycle after acceptance.
REQ-029 All four requesters valid continuously, MAX_BURST=4 -> grants 0,1,2,3,0 in order, 4 beats each, one IDLE cycle between bursts.
REQ-030 full=1 during GRANT -> req_ready=0 and wr_en=0 next cycle; full drops -> acceptance resumes, beat count unchanged by stall.
REQ-031 almostfull=1 with wr_en=1 -> req_ready=0 that cycle; with wr_en=0 -> one beat accepted.
REQ-032 Requester 2 drops req_valid after 2 beats -> IDLE next cycle, next grant search starts at requester 3.
REQ-033 Pulse overflow 3 times and wr_ack 5 times -> drop_cnt=3, ack_cnt=5; rst_n low mid-burst -> all outputs zero at once.
